// File: rtl/replay_ctrl.sv
// replay_ctrl: assigns TLP sequence numbers, checks ACK/NAK DLLPs against the unacked window, sequences replay and retrain.
// Latency: rb_we/rb_rd are combinational with their handshake; rb_purge, dll_err and retrain_req pulse one cycle after their cause.
// Backpressure: tlp_ready drops outside IDLE, with tx_ready low, or at MAX_INFLIGHT unacked TLPs; replay reads stall while tx_ready is low.
module replay_ctrl #(
    parameter int SEQ_W        = 12,
    parameter int MAX_INFLIGHT = 16,
    parameter int TIMEOUT      = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tlp_valid,
    output logic             tlp_ready,
    input  logic             tx_ready,
    input  logic             dll_valid,
    input  logic             dll_nak,
    input  logic [SEQ_W-1:0] dll_seq,
    input  logic             retrain_done,
    output logic             rb_we,
    output logic [SEQ_W-1:0] rb_wr_seq,
    output logic             rb_purge,
    output logic [SEQ_W-1:0] rb_purge_seq,
    output logic             rb_rd,
    output logic [SEQ_W-1:0] rb_rd_seq,
    output logic             replay_active,
    output logic             retrain_req,
    output logic             dll_err
);
    // The timer only ever counts up to TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SEQ_W-1:0] ONE        = SEQ_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, REPLAY = 2'd1, RETRAIN = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [SEQ_W-1:0] next_seq, acked_seq, rd_ptr;
    logic [1:0]       replay_num;
    logic [TW-1:0]    timer, timer_nxt;

    logic [SEQ_W-1:0] outstanding, dll_dist, acked_upd, next_seq_upd, outstanding_upd;
    logic [SEQ_W-1:0] rd_adv, rd_ofs, rd_fin;
    logic             accept_ok, hs, rd_issue;
    logic             dll_inwin, dll_dup, ack_ok, dll_bad;
    logic             expiry, replay_trig, replay_done, timer_run;

    // Window check, post-DLLP bookkeeping values and replay pointer advance.
    always_comb begin
        outstanding     = next_seq - acked_seq - ONE;
        accept_ok       = reset && tx_ready && (state == IDLE) && (outstanding < SEQ_W'(MAX_INFLIGHT));
        hs              = tlp_valid && accept_ok;
        rd_issue        = (state == REPLAY) && tx_ready;

        // Distance of the DLLP sequence past the last acked one; 0 is a repeat of the last ACK.
        dll_dist        = dll_seq - acked_seq;
        dll_inwin       = dll_valid && (dll_dist != '0) && (dll_dist <= outstanding);
        dll_dup         = dll_valid && (dll_dist == '0);
        ack_ok          = dll_inwin && !dll_nak;
        dll_bad         = dll_valid && !dll_inwin && !dll_dup;

        acked_upd       = dll_inwin ? dll_seq : acked_seq;
        next_seq_upd    = hs ? (next_seq + ONE) : next_seq;
        outstanding_upd = next_seq_upd - acked_upd - ONE;

        // An in-window ACK in the same cycle wins over timer expiry.
        expiry          = (state == IDLE) && (outstanding != '0) && (timer == TIMER_LAST) && !ack_ok;
        replay_trig     = (state == IDLE) && ((dll_nak && (dll_inwin || dll_dup)) || expiry);

        timer_run       = (state == IDLE) && (outstanding != '0) && !dll_inwin && !replay_trig;
        timer_nxt       = timer_run ? (timer + TW'(1)) : '0;

        // Skip past anything the DLLP just released so replay never re-sends acked TLPs.
        rd_adv          = rd_issue ? (rd_ptr + ONE) : rd_ptr;
        rd_ofs          = rd_adv - acked_seq - ONE;
        rd_fin          = (dll_inwin && (rd_ofs < dll_dist)) ? (dll_seq + ONE) : rd_adv;
        replay_done     = (rd_fin == next_seq);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: replay entry escalates to retrain after three replays without progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (replay_trig && (outstanding_upd != '0))
                    state_nxt = (replay_num == 2'd3) ? RETRAIN : REPLAY;
            end
            REPLAY: begin
                if (replay_done) state_nxt = IDLE;
            end
            RETRAIN: begin
                if (retrain_done) state_nxt = (outstanding_upd != '0) ? REPLAY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequence counters, replay pointer, retry count, timer and registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_seq     <= '0;
            acked_seq    <= '1;
            rd_ptr       <= '0;
            replay_num   <= 2'd0;
            timer        <= '0;
            rb_purge     <= 1'b0;
            rb_purge_seq <= '0;
            dll_err      <= 1'b0;
            retrain_req  <= 1'b0;
        end else begin
            next_seq     <= next_seq_upd;
            acked_seq    <= acked_upd;
            timer        <= timer_nxt;
            rb_purge     <= dll_inwin;
            if (dll_inwin) rb_purge_seq <= dll_seq;
            dll_err      <= dll_bad;
            retrain_req  <= (state == IDLE) && (state_nxt == RETRAIN);

            if ((state == IDLE) && (state_nxt == RETRAIN))
                replay_num <= 2'd0;
            else if ((state == IDLE) && (state_nxt == REPLAY))
                replay_num <= replay_num + 2'd1;
            else if (ack_ok)
                replay_num <= 2'd0;

            if ((state_nxt == REPLAY) && (state != REPLAY))
                rd_ptr <= acked_upd + ONE;
            else if (state == REPLAY)
                rd_ptr <= rd_fin;
        end
    end

    // Combinational outputs.
    always_comb begin
        tlp_ready     = accept_ok;
        rb_we         = hs;
        rb_wr_seq     = next_seq;
        rb_rd         = rd_issue;
        rb_rd_seq     = rd_ptr;
        replay_active = (state != IDLE);
    end
endmodule

// File: tb/tb_replay_ctrl.sv
// tb_replay_ctrl: scenario tasks for replay_ctrl with a queue scoreboard for writes, purges and replay reads.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: TLP sends wait for tlp_ready with a bounded cycle budget.
module tb_replay_ctrl;
    localparam int SEQ_W        = 12;
    localparam int MAX_INFLIGHT = 16;
    localparam int TIMEOUT      = 1000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tlp_valid = 1'b0;
    logic             tx_ready = 1'b0;
    logic             dll_valid = 1'b0;
    logic             dll_nak = 1'b0;
    logic [SEQ_W-1:0] dll_seq = '0;
    logic             retrain_done = 1'b0;
    logic             tlp_ready, rb_we, rb_purge, rb_rd, replay_active, retrain_req, dll_err;
    logic [SEQ_W-1:0] rb_wr_seq, rb_purge_seq, rb_rd_seq;

    replay_ctrl #(.SEQ_W(SEQ_W), .MAX_INFLIGHT(MAX_INFLIGHT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tx_ready(tx_ready),
        .dll_valid(dll_valid), .dll_nak(dll_nak), .dll_seq(dll_seq), .retrain_done(retrain_done),
        .rb_we(rb_we), .rb_wr_seq(rb_wr_seq), .rb_purge(rb_purge), .rb_purge_seq(rb_purge_seq),
        .rb_rd(rb_rd), .rb_rd_seq(rb_rd_seq), .replay_active(replay_active),
        .retrain_req(retrain_req), .dll_err(dll_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int n_err = 0;
    int n_retrain = 0;
    logic [SEQ_W-1:0] m_next;
    logic [SEQ_W-1:0] exp_we[$], obs_we[$], exp_purge[$], obs_purge[$], exp_rd[$], obs_rd[$];
    int obs_rd_cyc[$];

    always @(posedge clk) cyc++;

    // Collect DUT output events while out of reset.
    always @(negedge clk) begin
        if (reset) begin
            if (rb_we) obs_we.push_back(rb_wr_seq);
            if (rb_rd) begin
                obs_rd.push_back(rb_rd_seq);
                obs_rd_cyc.push_back(cyc);
            end
            if (rb_purge) obs_purge.push_back(rb_purge_seq);
            if (dll_err) n_err++;
            if (retrain_req) n_retrain++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_we.delete(); obs_we.delete(); exp_purge.delete(); obs_purge.delete();
        exp_rd.delete(); obs_rd.delete(); obs_rd_cyc.delete();
        n_err = 0; n_retrain = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tlp_valid = 1'b0; tx_ready = 1'b0; dll_valid = 1'b0; dll_nak = 1'b0;
        retrain_done = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        clear_sb();
        m_next = '0;
    endtask

    // Offer n TLPs; each accepted one predicts the next sequence number.
    task automatic send(input int n);
        bit done;
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            done = 1'b0;
            tlp_valid = 1'b1;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (tlp_ready) begin
                    exp_we.push_back(m_next);
                    hs_cyc = cyc;
                    m_next = m_next + 12'd1;
                    done = 1'b1;
                end
                step();
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL send_budget got=no_handshake exp=handshake seq=%0d", m_next);
            end
        end
        tlp_valid = 1'b0;
    endtask

    task automatic dllp(input logic nak, input logic [SEQ_W-1:0] seq);
        dll_valid = 1'b1; dll_nak = nak; dll_seq = seq;
        step();
        dll_valid = 1'b0; dll_nak = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tx_ready = 1'b1; tlp_valid = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({tlp_ready, rb_we, rb_purge, rb_rd, replay_active, retrain_req, dll_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000000",
                     {tlp_ready, rb_we, rb_purge, rb_rd, replay_active, retrain_req, dll_err});
        end
        checks++;
        if ({rb_wr_seq, rb_rd_seq, rb_purge_seq} !== 36'h0) begin
            failures++;
            $display("FAIL reset_seqs got=%h exp=0", {rb_wr_seq, rb_rd_seq, rb_purge_seq});
        end
        checks++;
        if ({dut.next_seq, dut.acked_seq, dut.rd_ptr, dut.replay_num, dut.timer} !==
            {12'h000, 12'hFFF, 12'h000, 2'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_state got=%h/%h/%h/%0d/%0d exp=000/fff/000/0/0",
                     dut.next_seq, dut.acked_seq, dut.rd_ptr, dut.replay_num, dut.timer);
        end
        step();
        reset = 1'b1; tlp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tlp_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", tlp_ready);
        end
        step();
    endtask

    task automatic test_ack_basic();
        logic [SEQ_W-1:0] e, o;
        do_reset();
        send(3);
        dllp(1'b0, 12'd2);
        exp_purge.push_back(12'd2);
        repeat (2) step();
        checks++;
        if (obs_we.size() != 3) begin
            failures++; $display("FAIL ack_we_count got=%0d exp=3", obs_we.size());
        end
        while (exp_we.size() > 0 && obs_we.size() > 0) begin
            e = exp_we.pop_front(); o = obs_we.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL ack_we_seq got=%0d exp=%0d", o, e); end
        end
        checks++;
        if (obs_purge.size() != 1) begin
            failures++; $display("FAIL ack_purge_count got=%0d exp=1", obs_purge.size());
        end
        while (exp_purge.size() > 0 && obs_purge.size() > 0) begin
            e = exp_purge.pop_front(); o = obs_purge.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL ack_purge_seq got=%0d exp=%0d", o, e); end
        end
        repeat (5) step();
        checks++;
        if (dut.outstanding !== 12'd0 || dut.timer !== 10'd0 || n_err != 0) begin
            failures++;
            $display("FAIL ack_idle got=out%0d/timer%0d/err%0d exp=0/0/0", dut.outstanding, dut.timer, n_err);
        end
    endtask

    task automatic test_nak_replay();
        logic [SEQ_W-1:0] e, o;
        do_reset();
        send(5);
        exp_we.delete(); obs_we.delete();
        dllp(1'b1, 12'd1);
        exp_purge.push_back(12'd1);
        exp_rd.push_back(12'd2); exp_rd.push_back(12'd3); exp_rd.push_back(12'd4);
        repeat (10) step();
        checks++;
        if (obs_rd.size() != 3 || obs_rd_cyc[1] - obs_rd_cyc[0] != 1 || obs_rd_cyc[2] - obs_rd_cyc[1] != 1) begin
            failures++; $display("FAIL nak_rd_burst got=count%0d exp=3_consecutive", obs_rd.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL nak_rd_seq got=%0d exp=%0d", o, e); end
        end
        while (exp_purge.size() > 0 && obs_purge.size() > 0) begin
            e = exp_purge.pop_front(); o = obs_purge.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL nak_purge_seq got=%0d exp=%0d", o, e); end
        end
        checks++;
        if (dut.replay_num !== 2'd1 || replay_active !== 1'b0) begin
            failures++;
            $display("FAIL nak_after got=num%0d/act%b exp=1/0", dut.replay_num, replay_active);
        end
        // Repeat NAK of the last acked sequence with the link stalled.
        obs_rd_cyc.delete();
        tx_ready = 1'b0;
        dllp(1'b1, 12'd1);
        repeat (5) step();
        checks++;
        if (obs_rd.size() != 0 || replay_active !== 1'b1 || obs_purge.size() != 0) begin
            failures++;
            $display("FAIL stall_hold got=rd%0d/act%b/purge%0d exp=0/1/0", obs_rd.size(), replay_active, obs_purge.size());
        end
        exp_rd.push_back(12'd2); exp_rd.push_back(12'd3); exp_rd.push_back(12'd4);
        tx_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (obs_rd.size() != 3) begin
            failures++; $display("FAIL stall_rd_count got=%0d exp=3", obs_rd.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL stall_rd_seq got=%0d exp=%0d", o, e); end
        end
        checks++;
        if (dut.replay_num !== 2'd2) begin
            failures++; $display("FAIL stall_num got=%0d exp=2", dut.replay_num);
        end
        dllp(1'b0, 12'd4);
        step();
        checks++;
        if (dut.replay_num !== 2'd0 || dut.outstanding !== 12'd0) begin
            failures++;
            $display("FAIL ack_clears_num got=num%0d/out%0d exp=0/0", dut.replay_num, dut.outstanding);
        end
    endtask

    task automatic test_timeout_retrain();
        int prev;
        do_reset();
        send(1);
        prev = hs_cyc;
        for (int r = 1; r <= 3; r++) begin
            for (int k = 0; k < TIMEOUT + 100 && obs_rd.size() == 0; k++) step();
            checks++;
            if (obs_rd.size() != 1) begin
                failures++; $display("FAIL timeout_%0d_rd got=count%0d exp=1", r, obs_rd.size());
            end else begin
                if (obs_rd[0] !== 12'd0 || obs_rd_cyc[0] - prev != TIMEOUT + 1 || dut.replay_num !== 2'(r)) begin
                    failures++;
                    $display("FAIL timeout_%0d got=seq%0d/gap%0d/num%0d exp=0/%0d/%0d",
                             r, obs_rd[0], obs_rd_cyc[0] - prev, dut.replay_num, TIMEOUT + 1, r);
                end
                prev = obs_rd_cyc[0];
            end
            obs_rd.delete(); obs_rd_cyc.delete();
        end
        for (int k = 0; k < TIMEOUT + 100 && n_retrain == 0; k++) step();
        repeat (20) step();
        checks++;
        if (n_retrain != 1 || obs_rd.size() != 0 || replay_active !== 1'b1 || dut.replay_num !== 2'd0) begin
            failures++;
            $display("FAIL retrain_hold got=req%0d/rd%0d/act%b/num%0d exp=1/0/1/0",
                     n_retrain, obs_rd.size(), replay_active, dut.replay_num);
        end
        retrain_done = 1'b1;
        step();
        retrain_done = 1'b0;
        repeat (3) step();
        checks++;
        if (obs_rd.size() != 1 || replay_active !== 1'b0 || dut.replay_num !== 2'd0) begin
            failures++;
            $display("FAIL retrain_replay got=rd%0d/act%b/num%0d exp=1/0/0", obs_rd.size(), replay_active, dut.replay_num);
        end else if (obs_rd[0] !== 12'd0) begin
            checks++; failures++;
            $display("FAIL retrain_rd_seq got=%0d exp=0", obs_rd[0]);
        end
    endtask

    task automatic test_full();
        logic [SEQ_W-1:0] e, o;
        do_reset();
        send(16);
        checks++;
        if (obs_we.size() != 16) begin
            failures++; $display("FAIL full_we_count got=%0d exp=16", obs_we.size());
        end
        while (exp_we.size() > 0 && obs_we.size() > 0) begin
            e = exp_we.pop_front(); o = obs_we.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL full_we_seq got=%0d exp=%0d", o, e); end
        end
        tlp_valid = 1'b1;
        repeat (3) step();
        tlp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tlp_ready !== 1'b0 || dut.outstanding !== 12'd16 || obs_we.size() != 0) begin
            failures++;
            $display("FAIL full_block got=rdy%b/out%0d/we%0d exp=0/16/0", tlp_ready, dut.outstanding, obs_we.size());
        end
        step();
        dllp(1'b0, 12'd0);
        @(negedge clk);
        checks++;
        if (tlp_ready !== 1'b1) begin
            failures++; $display("FAIL full_release got=%b exp=1", tlp_ready);
        end
    endtask

    task automatic test_wrap();
        logic [SEQ_W-1:0] e, o;
        int n;
        do_reset();
        while (m_next != 12'd4094) begin
            n = 4094 - int'(m_next);
            if (n > 14) n = 14;
            send(n);
            dllp(1'b0, m_next - 12'd1);
        end
        step();
        clear_sb();
        send(4);
        exp_purge.push_back(12'd1);
        dllp(1'b0, 12'd1);
        repeat (2) step();
        checks++;
        if (obs_we.size() != 4) begin
            failures++; $display("FAIL wrap_we_count got=%0d exp=4", obs_we.size());
        end
        while (exp_we.size() > 0 && obs_we.size() > 0) begin
            e = exp_we.pop_front(); o = obs_we.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_we_seq got=%0d exp=%0d", o, e); end
        end
        while (exp_purge.size() > 0 && obs_purge.size() > 0) begin
            e = exp_purge.pop_front(); o = obs_purge.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_purge_seq got=%0d exp=%0d", o, e); end
        end
        checks++;
        if (dut.outstanding !== 12'd0 || n_err != 0) begin
            failures++; $display("FAIL wrap_drained got=out%0d/err%0d exp=0/0", dut.outstanding, n_err);
        end
        dllp(1'b0, 12'd7);
        repeat (2) step();
        checks++;
        if (n_err != 1 || obs_purge.size() != 0 || dut.acked_seq !== 12'd1) begin
            failures++;
            $display("FAIL wrap_bad_ack got=err%0d/purge%0d/acked%0d exp=1/0/1", n_err, obs_purge.size(), dut.acked_seq);
        end
        dllp(1'b0, 12'd1);
        repeat (2) step();
        checks++;
        if (n_err != 1 || obs_purge.size() != 0) begin
            failures++; $display("FAIL wrap_dup_ack got=err%0d/purge%0d exp=1/0", n_err, obs_purge.size());
        end
    endtask

    task automatic test_reset_replay();
        do_reset();
        send(3);
        tx_ready = 1'b0;
        dllp(1'b1, 12'd0);
        step();
        tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rb_rd !== 1'b1 || rb_rd_seq !== 12'd1 || replay_active !== 1'b1) begin
            failures++;
            $display("FAIL mid_replay got=rd%b/seq%0d/act%b exp=1/1/1", rb_rd, rb_rd_seq, replay_active);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rb_rd !== 1'b0 || replay_active !== 1'b0 || rb_rd_seq !== 12'd0 || rb_purge_seq !== 12'd0) begin
            failures++;
            $display("FAIL reset_abort got=rd%b/act%b/rseq%0d/pseq%0d exp=0/0/0/0",
                     rb_rd, replay_active, rb_rd_seq, rb_purge_seq);
        end
        checks++;
        if ({dut.next_seq, dut.acked_seq, dut.rd_ptr, dut.replay_num, dut.timer} !==
            {12'h000, 12'hFFF, 12'h000, 2'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_abort_state got=%h/%h/%h/%0d/%0d exp=000/fff/000/0/0",
                     dut.next_seq, dut.acked_seq, dut.rd_ptr, dut.replay_num, dut.timer);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rb_rd !== 1'b0 || tlp_ready !== 1'b0) begin
            failures++; $display("FAIL reset_hold got=rd%b/rdy%b exp=0/0", rb_rd, tlp_ready);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_ack_basic();
        test_nak_replay();
        test_timeout_retrain();
        test_full();
        test_wrap();
        test_reset_replay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
